// File: rtl/walksat_ctrl_pkg.sv
// Shared definitions for the WalkSAT step controller: state encoding,
// control-word field positions, sub-field encodings and the LFSR step.
package walksat_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_EVAL     = 4'd2,
    ST_CHECK    = 4'd3,
    ST_POP      = 4'd4,
    ST_FETCH    = 4'd5,
    ST_BREAK    = 4'd6,
    ST_SELECT   = 4'd7,
    ST_FLIP     = 4'd8,
    ST_DONE_SAT = 4'd9,
    ST_DONE_TO  = 4'd10
  } state_e;

  // Bit positions inside the 14-bit control word
  localparam int CW_CR_WR_EN    = 0;
  localparam int CW_VT_EN       = 1;
  localparam int CW_VT_WR_EN    = 2;
  localparam int CW_UCB_OP_LO   = 3;
  localparam int CW_BC_EN       = 5;
  localparam int CW_EVAL_EN     = 6;
  localparam int CW_FIFO_WR_EN  = 7;
  localparam int CW_FIFO_RD_EN  = 8;
  localparam int CW_LIT_SEL_LO  = 9;
  localparam int CW_SEL_MODE_LO = 11;
  localparam int CW_RESERVED    = 13;

  typedef enum logic [1:0] {
    UCB_NOP   = 2'b00,
    UCB_PUSH  = 2'b01,
    UCB_POP   = 2'b10,
    UCB_CLEAR = 2'b11
  } ucb_op_e;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'b00,
    SEL_GREEDY = 2'b01,
    SEL_RANDOM = 2'b10
  } sel_mode_e;

  // Fibonacci step, taps 16,14,13,11 (bit indices 15,13,12,10), shifting left
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

endpackage

// File: rtl/walksat_step_controller_if.sv
// Handshake/status bundle between the host side and the step controller.
interface walksat_step_controller_if #(
  parameter int CONTROLLER_SIGNAL_WIDTH = 14,
  parameter int FLIP_CNT_WIDTH          = 32
);
  logic                               start_i;
  logic                               abort_i;
  logic [FLIP_CNT_WIDTH-1:0]          max_flips_i;
  logic [15:0]                        noise_p_i;
  logic                               eval_done_i;
  logic                               unsat_empty_i;
  logic                               break_done_i;
  logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o;
  logic                               busy_o;
  logic                               sat_o;
  logic                               timeout_o;
  logic [FLIP_CNT_WIDTH-1:0]          flip_count_o;

  modport master (
    output start_i, abort_i, max_flips_i, noise_p_i,
           eval_done_i, unsat_empty_i, break_done_i,
    input  control_signal_o, busy_o, sat_o, timeout_o, flip_count_o
  );

  modport slave (
    input  start_i, abort_i, max_flips_i, noise_p_i,
           eval_done_i, unsat_empty_i, break_done_i,
    output control_signal_o, busy_o, sat_o, timeout_o, flip_count_o
  );
endinterface

// File: rtl/walksat_lfsr16.sv
// 16-bit Fibonacci LFSR used for the random-walk decision; loads seed on reset.
module walksat_lfsr16
  import walksat_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  // Load seed on reset, otherwise step only when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= seed;
    end else if (en) begin
      value <= lfsr16_next(value);
    end
  end

endmodule

// File: rtl/walksat_step_controller.sv
// WalkSAT step sequencer: drives the december_top_file control word through
// eval -> check -> pop -> fetch -> break -> select -> flip, one flip per loop.
module walksat_step_controller
  import walksat_ctrl_pkg::*;
#(
  parameter int          NSAT                    = 3,
  parameter int          CONTROLLER_SIGNAL_WIDTH = 14,
  parameter int          FLIP_CNT_WIDTH          = 32,
  parameter logic [15:0] LFSR_SEED               = 16'hACE1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  walksat_step_controller_if.slave bus
);

  state_e                             state_r, state_nxt;
  logic [1:0]                         fetch_idx_r, fetch_idx_nxt;
  logic [CONTROLLER_SIGNAL_WIDTH-1:0] ctrl_r, word_nxt;
  logic                               busy_r, busy_nxt;
  logic                               sat_r, timeout_r;
  logic [FLIP_CNT_WIDTH-1:0]          flip_count_r, max_flips_r;
  logic [15:0]                        lfsr_value;
  logic                               lfsr_en;

  // The LFSR advances exactly once per SELECT cycle
  assign lfsr_en = (state_r == ST_SELECT);

  walksat_lfsr16 u_lfsr (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .value (lfsr_value)
  );

  // Next-state and fetch-index logic; abort overrides every transition
  always_comb begin
    state_nxt     = state_r;
    fetch_idx_nxt = fetch_idx_r;
    if (bus.abort_i) begin
      state_nxt     = ST_IDLE;
      fetch_idx_nxt = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE_SAT, ST_DONE_TO: begin
          if (bus.start_i) state_nxt = ST_INIT;
          else             state_nxt = state_r;
        end
        ST_INIT: state_nxt = ST_EVAL;
        ST_EVAL: begin
          if (bus.eval_done_i) state_nxt = ST_CHECK;
          else                 state_nxt = ST_EVAL;
        end
        ST_CHECK: begin
          if (bus.unsat_empty_i)               state_nxt = ST_DONE_SAT;
          else if (flip_count_r == max_flips_r) state_nxt = ST_DONE_TO;
          else                                  state_nxt = ST_POP;
        end
        ST_POP: begin
          state_nxt     = ST_FETCH;
          fetch_idx_nxt = 2'd0;
        end
        ST_FETCH: begin
          if (fetch_idx_r == 2'(NSAT - 1)) begin
            state_nxt     = ST_BREAK;
            fetch_idx_nxt = 2'd0;
          end else begin
            state_nxt     = ST_FETCH;
            fetch_idx_nxt = fetch_idx_r + 2'd1;
          end
        end
        ST_BREAK: begin
          if (bus.break_done_i) state_nxt = ST_SELECT;
          else                  state_nxt = ST_BREAK;
        end
        ST_SELECT: state_nxt = ST_FLIP;
        ST_FLIP:   state_nxt = ST_EVAL;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control word and busy flag for the state being entered, so the
  // registered copies line up with the state register
  always_comb begin
    word_nxt = '0;
    busy_nxt = 1'b1;
    case (state_nxt)
      ST_INIT: begin
        word_nxt[CW_UCB_OP_LO +: 2] = UCB_CLEAR;
        word_nxt[CW_EVAL_EN]        = 1'b1;
      end
      ST_EVAL: word_nxt[CW_EVAL_EN] = 1'b1;
      ST_POP: begin
        word_nxt[CW_UCB_OP_LO +: 2] = UCB_POP;
        word_nxt[CW_CR_WR_EN]       = 1'b1;
      end
      ST_FETCH: begin
        word_nxt[CW_VT_EN]           = 1'b1;
        word_nxt[CW_FIFO_WR_EN]      = 1'b1;
        word_nxt[CW_LIT_SEL_LO +: 2] = fetch_idx_nxt;
      end
      ST_BREAK: word_nxt[CW_BC_EN] = 1'b1;
      ST_SELECT: begin
        if (lfsr_value < bus.noise_p_i) word_nxt[CW_SEL_MODE_LO +: 2] = SEL_RANDOM;
        else                            word_nxt[CW_SEL_MODE_LO +: 2] = SEL_GREEDY;
      end
      ST_FLIP: begin
        word_nxt[CW_VT_EN]      = 1'b1;
        word_nxt[CW_VT_WR_EN]   = 1'b1;
        word_nxt[CW_FIFO_RD_EN] = 1'b1;
      end
      ST_IDLE, ST_DONE_SAT, ST_DONE_TO: busy_nxt = 1'b0;
      default: word_nxt = '0;
    endcase
    word_nxt[CW_RESERVED] = 1'b0;
  end

  // State, registered outputs, run flags and the saturating flip counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      fetch_idx_r  <= 2'd0;
      ctrl_r       <= '0;
      busy_r       <= 1'b0;
      sat_r        <= 1'b0;
      timeout_r    <= 1'b0;
      flip_count_r <= '0;
      max_flips_r  <= '0;
    end else begin
      state_r     <= state_nxt;
      fetch_idx_r <= fetch_idx_nxt;
      ctrl_r      <= word_nxt;
      busy_r      <= busy_nxt;
      if (bus.abort_i) begin
        sat_r     <= 1'b0;
        timeout_r <= 1'b0;
      end else if (state_nxt == ST_INIT) begin
        sat_r        <= 1'b0;
        timeout_r    <= 1'b0;
        flip_count_r <= '0;
        max_flips_r  <= bus.max_flips_i;
      end else begin
        if (state_r == ST_CHECK && state_nxt == ST_DONE_SAT) sat_r <= 1'b1;
        if (state_r == ST_CHECK && state_nxt == ST_DONE_TO)  timeout_r <= 1'b1;
        if (state_nxt == ST_FLIP && flip_count_r != {FLIP_CNT_WIDTH{1'b1}})
          flip_count_r <= flip_count_r + FLIP_CNT_WIDTH'(1);
      end
    end
  end

  assign bus.control_signal_o = ctrl_r;
  assign bus.busy_o           = busy_r;
  assign bus.sat_o            = sat_r;
  assign bus.timeout_o        = timeout_r;
  assign bus.flip_count_o     = flip_count_r;

endmodule
